// File: rtl/fetch_queue_ifu_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_ifu_if
// Brief    : Redirect, instruction-memory and decode-side bundle for the IFU.
// Revision : 1.0
// ============================================================================
interface fetch_queue_ifu_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_adel;

    modport master (
        input  redirect, redirect_pc, imem_rvalid, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_pc, out_instr, out_adel
    );

    modport slave (
        output redirect, redirect_pc, imem_rvalid, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_pc, out_instr, out_adel
    );
endinterface
`default_nettype wire

// File: rtl/fetch_queue_ifu.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_ifu
// Brief    : Sequential fetch unit with a QDEPTH-entry prefetch queue and redirect.
// Revision : 1.0
// ============================================================================
module fetch_queue_ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] TEXT_LO  = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI  = 32'h0000_6FFF,
    parameter int          QDEPTH   = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    fetch_queue_ifu_if.master  bus
);
    localparam int PW = $clog2(QDEPTH);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;

    logic [31:0]   q_pc_q    [QDEPTH];
    logic [31:0]   q_instr_q [QDEPTH];
    logic          q_adel_q  [QDEPTH];

    logic          pc_legal, credit, issue, push_adel, push_resp, push, pop;
    logic [PW+1:0] occupancy;
    logic [31:0]   push_pc, push_instr;

    always_comb begin
        pc_legal  = (fetch_pc_q[1:0] == 2'b00) && (fetch_pc_q >= TEXT_LO) && (fetch_pc_q <= TEXT_HI);
        // An outstanding request already owns a queue slot.
        occupancy = {1'b0, count_q} + {{(PW+1){1'b0}}, (state_q == ST_WAIT)};
        credit    = occupancy < (PW+2)'(QDEPTH);
        issue     = !reset && !bus.redirect && credit && pc_legal &&
                    ((state_q == ST_RUN) || ((state_q == ST_WAIT) && bus.imem_rvalid));
        push_adel = !bus.redirect && (state_q == ST_RUN) && credit && !pc_legal;
        push_resp = !bus.redirect && (state_q == ST_WAIT) && bus.imem_rvalid;
        push      = push_adel || push_resp;
        pop       = (count_q != '0) && bus.out_ready && !bus.redirect;
        push_pc    = push_adel ? fetch_pc_q : req_pc_q;
        push_instr = push_adel ? 32'h0 : bus.imem_rdata;
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = issue ? fetch_pc_q : 32'h0;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_pc    = bus.out_valid ? q_pc_q[rd_ptr_q]    : 32'h0;
    assign bus.out_instr = bus.out_valid ? q_instr_q[rd_ptr_q] : 32'h0;
    assign bus.out_adel  = bus.out_valid ? q_adel_q[rd_ptr_q]  : 1'b0;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // A response still in flight must be swallowed before fetch restarts.
            state_d    = (((state_q == ST_WAIT) || (state_q == ST_DROP)) && !bus.imem_rvalid)
                         ? ST_DROP : ST_RUN;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                req_pc_d   = fetch_pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
            case (state_q)
                ST_RUN: begin
                    if (issue)          state_d = ST_WAIT;
                    else if (push_adel) state_d = ST_HALT;
                end
                ST_WAIT: if (bus.imem_rvalid) state_d = issue ? ST_WAIT : ST_RUN;
                ST_DROP: if (bus.imem_rvalid) state_d = ST_RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= 32'h0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            q_pc_q[wr_ptr_q]    <= push_pc;
            q_instr_q[wr_ptr_q] <= push_instr;
            q_adel_q[wr_ptr_q]  <= push_adel;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_ifu.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue_ifu
// Brief    : Self-checking bench for fetch_queue_ifu against a program-order model.
// Revision : 1.0
// ============================================================================
module tb_fetch_queue_ifu;
    localparam int QDEPTH = 4;

    logic clk;
    logic reset;
    fetch_queue_ifu_if bus();

    fetch_queue_ifu #(
        .RESET_PC(32'h0000_3000), .TEXT_LO(32'h0000_3000),
        .TEXT_HI(32'h0000_6FFF),  .QDEPTH(QDEPTH)
    ) u_dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Environment/model state
    int          ready_mode;   // 0 random, 1 always, 2 never
    int          lat_fix;      // <0 random 0..2 extra cycles
    bit          rnd_redir;
    bit          redir_req;
    logic [31:0] redir_addr;
    bit          pend;
    int          pend_wait;
    logic [31:0] pend_addr;
    logic [31:0] exp_fetch, exp_out;
    bit          exp_done;
    int          alive;
    int          n_req, n_pop;
    logic [31:0] last_addr;
    logic        s_req, s_valid, s_adel;
    logic [31:0] s_addr, s_pc, s_instr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a >= 32'h3000) && (a <= 32'h6FFF);
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 7))
            0:       return 32'h2FFC;
            1:       return 32'h3002;
            2:       return 32'h7000;
            3:       return 32'h6FF0 + 4 * $urandom_range(0, 3);
            default: return 32'h3000 + 4 * $urandom_range(0, 32'hFFF);
        endcase
    endfunction

    task automatic restart_model(input logic [31:0] pc);
        exp_fetch = pc;
        exp_out   = pc;
        exp_done  = 1'b0;
        alive     = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.redirect = 1'b0;
        bus.imem_rvalid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_req",   32'(bus.imem_req),  32'd0);
        chk("rst_addr",  bus.imem_addr,      32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_pc",    bus.out_pc,         32'd0);
        chk("rst_instr", bus.out_instr,      32'd0);
        chk("rst_adel",  32'(bus.out_adel),  32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pend = 1'b0;
        restart_model(32'h3000);
    endtask

    // One clock cycle: drive inputs, sample outputs, update the reference model.
    task automatic step();
        bit e_adel;
        #1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        if (pend && pend_wait == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = memf(pend_addr);
        end
        case (ready_mode)
            0:       bus.out_ready = 1'($urandom_range(0, 1));
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'b0;
        endcase
        bus.redirect = 1'b0;
        if (redir_req) begin
            bus.redirect    = 1'b1;
            bus.redirect_pc = redir_addr;
            redir_req       = 1'b0;
        end else if (rnd_redir && $urandom_range(0, 19) == 0) begin
            bus.redirect    = 1'b1;
            bus.redirect_pc = pick_target();
        end
        #1;
        s_req = bus.imem_req;   s_addr  = bus.imem_addr;
        s_valid = bus.out_valid; s_pc   = bus.out_pc;
        s_instr = bus.out_instr; s_adel = bus.out_adel;

        if (bus.redirect) chk("redir_noreq", 32'(s_req), 32'd0);
        if (s_req) begin
            chk("one_outstanding", 32'(pend && !bus.imem_rvalid), 32'd0);
            chk("req_addr",  s_addr, exp_fetch);
            chk("req_legal", 32'(legal(s_addr)), 32'd1);
            chk("credit",    32'(alive < QDEPTH), 32'd1);
            exp_fetch = exp_fetch + 32'd4;
            alive++;
            n_req++;
            last_addr = s_addr;
        end
        if (s_valid && bus.out_ready && !bus.redirect) begin
            n_pop++;
            if (exp_done) begin
                chk("extra_entry", 32'd1, 32'd0);
            end else begin
                e_adel = !legal(exp_out);
                chk("out_pc",    s_pc, exp_out);
                chk("out_adel",  32'(s_adel), 32'(e_adel));
                chk("out_instr", s_instr, e_adel ? 32'h0 : memf(exp_out));
                if (e_adel) exp_done = 1'b1;
                else begin
                    exp_out = exp_out + 32'd4;
                    alive--;
                end
            end
        end
        if (bus.imem_rvalid) pend = 1'b0;
        else if (pend) pend_wait--;
        if (s_req) begin
            pend      = 1'b1;
            pend_addr = s_addr;
            pend_wait = (lat_fix < 0) ? int'($urandom_range(0, 2)) : lat_fix;
        end
        if (bus.redirect) restart_model(bus.redirect_pc);
        @(posedge clk);
    endtask

    initial begin
        int r0, p0;
        logic [31:0] adel_tbl [3];
        adel_tbl[0] = 32'h2FFC; adel_tbl[1] = 32'h3002; adel_tbl[2] = 32'h7000;
        ready_mode = 1; lat_fix = 0; rnd_redir = 1'b0; redir_req = 1'b0;
        redir_addr = '0; n_req = 0; n_pop = 0; last_addr = '0;
        bus.out_ready = 1'b0; bus.redirect_pc = '0; bus.imem_rdata = '0;

        // Streaming with single-cycle memory
        do_reset();
        step();
        chk("first_req",  32'(s_req), 32'd1);
        chk("first_addr", s_addr, 32'h3000);
        step();
        chk("valid_c1", 32'(s_valid), 32'd0);
        step();
        chk("valid_c2", 32'(s_valid), 32'd1);
        chk("pc_c2",    s_pc, 32'h3000);
        r0 = n_req;
        repeat (8) step();
        chk("stream_rate", 32'(n_req - r0), 32'd8);

        // Mid-stream reset, then backpressure
        do_reset();
        ready_mode = 2;
        r0 = n_req;
        repeat (12) step();
        chk("bp_reqs",  32'(n_req - r0), 32'd4);
        chk("bp_last",  last_addr, 32'h300C);
        chk("bp_idle",  32'(s_req), 32'd0);
        chk("bp_valid", 32'(s_valid), 32'd1);
        ready_mode = 1;
        step();
        chk("bp_pop_noreq", 32'(s_req), 32'd0);
        step();
        chk("bp_resume",      32'(s_req), 32'd1);
        chk("bp_resume_addr", s_addr, 32'h3010);

        // Redirect while a 3-cycle response is outstanding
        do_reset();
        lat_fix = 2;
        step();
        redir_req = 1'b1; redir_addr = 32'h4180;
        step();
        step();
        chk("drop_valid2", 32'(s_valid), 32'd0);
        step();
        chk("drop_valid3", 32'(s_valid), 32'd0);
        chk("drop_noreq",  32'(s_req), 32'd0);
        step();
        chk("redir_req",  32'(s_req), 32'd1);
        chk("redir_addr", s_addr, 32'h4180);
        p0 = n_pop;
        repeat (6) step();
        chk("redir_flow", 32'(n_pop - p0 > 0), 32'd1);

        // Address errors
        lat_fix = 0;
        for (int i = 0; i < 3; i++) begin
            ready_mode = 2;
            redir_req = 1'b1; redir_addr = adel_tbl[i];
            step();
            r0 = n_req;
            repeat (6) step();
            chk("adel_noreq", 32'(n_req - r0), 32'd0);
            chk("adel_valid", 32'(s_valid), 32'd1);
            chk("adel_pc",    s_pc, adel_tbl[i]);
            chk("adel_flag",  32'(s_adel), 32'd1);
            chk("adel_instr", s_instr, 32'd0);
            ready_mode = 1;
            step();
            ready_mode = 2;
            step();
            chk("adel_single", 32'(s_valid), 32'd0);
        end

        // Top-of-text boundary
        ready_mode = 1;
        redir_req = 1'b1; redir_addr = 32'h6FFC;
        step();
        r0 = n_req; p0 = n_pop;
        repeat (8) step();
        chk("bnd_reqs", 32'(n_req - r0), 32'd1);
        chk("bnd_addr", last_addr, 32'h6FFC);
        chk("bnd_pops", 32'(n_pop - p0), 32'd2);

        // Redirect coinciding with a response and a pop
        do_reset();
        repeat (5) step();
        redir_req = 1'b1; redir_addr = 32'h5000;
        step();
        step();
        chk("sim_empty", 32'(s_valid), 32'd0);
        chk("sim_req",   32'(s_req), 32'd1);
        chk("sim_addr",  s_addr, 32'h5000);

        // Randomized traffic
        do_reset();
        ready_mode = 0; lat_fix = -1; rnd_redir = 1'b1;
        p0 = n_pop;
        repeat (1500) step();
        chk("rand_progress", 32'(n_pop - p0 > 50), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
